dcache_mem_ctrl: RTL

//  Memory-side controller directly downstream of the L1 data cache, placed between the cache and the backing data memory.

---
 rtl/dcache_mem_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/dcache_mem_ctrl.sv
// Memory-side controller below the L1 D-cache: fixed-latency line refills plus a
// write-through store buffer drained to memory whenever no refill is in progress.
module dcache_mem_ctrl #(
    parameter int RD_LAT   = 2,
    parameter int WB_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_req,
    input  logic [31:0] rd_addr,
    output logic        rd_valid,
    output logic [63:0] rd_data,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_full,
    output logic        wb_empty,
    output logic [31:0] mem_addr,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam int PW   = $clog2(WB_DEPTH);
    localparam int CW   = PW + 1;
    localparam int CNTW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    typedef enum logic [1:0] {IDLE, DRAIN, RWAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [CNTW-1:0] cnt, cnt_nxt;
    logic [CW-1:0]   count, dleft, dleft_nxt;
    logic [PW-1:0]   wptr, rptr;
    logic [31:0]     fa [WB_DEPTH];
    logic [31:0]     fd [WB_DEPTH];
    logic            push, pop, capture, hit, hz;

    assign push = wr_req && (count != CW'(WB_DEPTH));
    assign hz   = rd_req && hit;

    // Only entries between the read pointer and read pointer + count are live.
    always_comb begin
        logic [PW-1:0] off;
        hit = 1'b0;
        off = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            off = PW'(i) - rptr;
            if (({1'b0, off} < count) && (fa[i][17:3] == rd_addr[17:3])) begin
                hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        dleft_nxt = dleft;
        pop       = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (rd_req) begin
                    if (hz) begin
                        state_nxt = DRAIN;
                        dleft_nxt = count;
                    end else begin
                        state_nxt = RWAIT;
                        cnt_nxt   = CNTW'(RD_LAT - 1);
                    end
                end else if (count != '0) begin
                    pop = 1'b1;
                end
            end
            // Drain exactly the entries present on entry; later pushes wait.
            DRAIN: begin
                pop       = 1'b1;
                dleft_nxt = dleft - 1'b1;
                if (dleft == CW'(1)) begin
                    state_nxt = RWAIT;
                    cnt_nxt   = CNTW'(RD_LAT - 1);
                end
            end
            RWAIT: begin
                if (cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            dleft   <= '0;
            count   <= '0;
            wptr    <= '0;
            rptr    <= '0;
            rd_data <= '0;
            for (int i = 0; i < WB_DEPTH; i++) begin
                fa[i] <= '0;
                fd[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            dleft <= dleft_nxt;
            if (push) begin
                fa[wptr] <= wr_addr;
                fd[wptr] <= wr_data;
                wptr     <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (capture) begin
                rd_data <= mem_rdata;
            end
        end
    end

    assign rd_valid  = (state == RESP);
    assign wr_full   = (count == CW'(WB_DEPTH));
    assign wb_empty  = (count == '0);
    assign mem_write = pop;
    assign mem_addr  = (state == RWAIT || state == RESP) ? {rd_addr[31:3], 3'b000} : fa[rptr];
    assign mem_wdata = fd[rptr];

endmodule
